// File: rtl/cpu_pkg.sv
// Shared CPU-wide types: program-counter width and PC type.
package cpu_pkg;
  localparam int PC_W = 12;
  typedef logic [PC_W-1:0] pc_t;
endpackage : cpu_pkg

// File: rtl/pc_stack_mem.sv
// DEPTH x ADDR_W register array: one synchronous write port, one async read port.
// Entries carry no reset; only the pointer/count logic in the parent is reset.
module pc_stack_mem #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int SP_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SP_W-1:0]   waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [SP_W-1:0]   raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : pc_stack_mem

// File: rtl/pc_return_stack.sv
// Return-address stack for JSR/RET: zero-latency top_addr, sticky overflow/underflow flags.
// Overflowing pushes and underflowing pops leave the stack untouched; push+pop replaces the top.
module pc_return_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_addr,
  output logic [ADDR_W-1:0]        top_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = SP_W + 1;

  logic [SP_W-1:0]   r_sp;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;

  logic              w_empty;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_do_replace;
  logic              w_we;
  logic [SP_W-1:0]   w_top_idx;
  logic [SP_W-1:0]   w_waddr;
  logic [ADDR_W-1:0] w_rdata;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  // When full, r_sp has wrapped to 0, so sp-1 still lands on the top entry.
  assign w_top_idx = r_sp - SP_W'(1);

  // push+pop on an empty stack degenerates to a plain push; DEPTH>=2 means it cannot be full.
  assign w_do_replace = push & pop & ~w_empty;
  assign w_do_push    = (push & ~pop & ~w_full) | (push & pop & w_empty);
  assign w_do_pop     = pop & ~push & ~w_empty;

  assign w_we    = ~rst & (w_do_push | w_do_replace);
  assign w_waddr = w_do_replace ? w_top_idx : r_sp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_sp    <= r_sp + SP_W'(1);
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop) begin
        r_sp    <= w_top_idx;
        r_count <= r_count - CNT_W'(1);
      end
      if (push & ~pop & w_full) begin
        r_ovf <= 1'b1;
      end
      if (pop & ~push & w_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  pc_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SP_W   (SP_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (push_addr),
    .raddr (w_top_idx),
    .rdata (w_rdata)
  );

  assign top_addr = w_empty ? '0 : w_rdata;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

endmodule : pc_return_stack
